// File: rtl/word_packer_10to21_if.sv
// Handshake bundle for word_packer_10to21: symbol input side, word output side and fill level.
// Under PACKER_FLUSH_EN the bundle also carries flush and out_partial.
interface word_packer_10to21_if #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 21,
  parameter int CNT_W = 5
) ();
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] fill;
`ifdef PACKER_FLUSH_EN
  logic             flush;
  logic             out_partial;
`endif

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, fill
`ifdef PACKER_FLUSH_EN
    , input flush, output out_partial
`endif
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, fill
`ifdef PACKER_FLUSH_EN
    , output flush, input out_partial
`endif
  );
endinterface

// File: rtl/word_packer_10to21.sv
// Gearbox packing 10-bit symbols into 21-bit words LSB-first through a 31-bit accumulator.
// Optional macro PACKER_FLUSH_EN adds flush/out_partial to emit a zero-padded partial word.
module word_packer_10to21 #(
  parameter int IN_W  = 10,
  parameter int OUT_W = 21,
  parameter int CNT_W = 5
) (
  input logic                clk,
  input logic                rst_n,
  word_packer_10to21_if.slave bus
);
  localparam int ACC_W = OUT_W + IN_W;
  localparam logic [CNT_W-1:0] IN_W_C  = CNT_W'(IN_W);
  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);
  localparam logic [3:0] PHASE_LAST = 4'd9;

  logic [ACC_W-1:0] acc_q, acc_d, acc_sh_s;
  logic [CNT_W-1:0] fill_q, fill_d, fill_sh_s;
  logic [3:0]       phase_q, phase_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept_s, emit_s;
`ifdef PACKER_FLUSH_EN
  logic             partial_q, partial_d;
`endif

  // Next-state: shift out the emitted word first, then insert the new symbol at the new fill.
  always_comb begin
    accept_s = bus.in_valid & in_ready_q;
    emit_s   = out_valid_q & bus.out_ready;
    if (emit_s) begin
      acc_sh_s  = acc_q >> OUT_W;
      fill_sh_s = fill_q - OUT_W_C;
      phase_d   = (phase_q == PHASE_LAST) ? 4'd0 : phase_q + 4'd1;
    end else begin
      acc_sh_s  = acc_q;
      fill_sh_s = fill_q;
      phase_d   = phase_q;
    end
    acc_d = acc_sh_s;
    if (accept_s) begin
      acc_d[fill_sh_s +: IN_W] = bus.in_data;
      fill_d = fill_sh_s + IN_W_C;
    end else begin
      fill_d = fill_sh_s;
    end
`ifdef PACKER_FLUSH_EN
    // Bits above fill are always zero, so a partial word is just acc as it stands.
    partial_d = partial_q;
    if (partial_q && emit_s) begin
      acc_d     = '0;
      fill_d    = '0;
      phase_d   = 4'd0;
      partial_d = 1'b0;
    end else if (bus.flush && !partial_q && !accept_s &&
                 (fill_q != '0) && (fill_q < OUT_W_C)) begin
      partial_d = 1'b1;
    end else begin
      partial_d = partial_q;
    end
    in_ready_d  = (fill_d <= OUT_W_C) && !partial_d;
    out_valid_d = (fill_d >= OUT_W_C) || partial_d;
`else
    in_ready_d  = (fill_d <= OUT_W_C);
    out_valid_d = (fill_d >= OUT_W_C);
`endif
  end

  // State and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      fill_q      <= '0;
      phase_q     <= 4'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef PACKER_FLUSH_EN
      partial_q   <= 1'b0;
`endif
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      phase_q     <= phase_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef PACKER_FLUSH_EN
      partial_q   <= partial_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = acc_q[OUT_W-1:0];
  assign bus.fill      = fill_q;
`ifdef PACKER_FLUSH_EN
  assign bus.out_partial = partial_q;
`endif
endmodule
